// File: rtl/chaos_keystream_xor.sv
// Chaotic keystream encryptor: quantizes float samples into key bytes, buffers them, XORs pixel frames.
// Optional macro CIPHER_FEEDBACK_EN adds ciphertext chaining seeded by iv.
module chaos_keystream_xor #(
    parameter int PRECISION    = 32,
    parameter int FRAC_SHIFT   = 16,
    parameter int FIFO_DEPTH   = 64,
    parameter int AFULL_MARGIN = 56,
    parameter int FRAME_PIXELS = 65536
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sawtooth_valid,
    input  logic [PRECISION-1:0] result,
    output logic                 key_afull,
    output logic                 key_overflow,
    input  logic                 start,
    input  logic [7:0]           iv,
    input  logic                 pixel_tvalid,
    output logic                 pixel_tready,
    input  logic [7:0]           pixel_tdata,
    output logic                 cipher_tvalid,
    input  logic                 cipher_tready,
    output logic [7:0]           cipher_tdata,
    output logic                 cipher_tlast,
    output logic                 frame_done,
    output logic                 busy
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam logic [AW:0]       FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]       AFULL_TH = (AW+1)'(FIFO_DEPTH - AFULL_MARGIN);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(FRAME_PIXELS - 1);
    localparam logic signed [15:0] S_BIAS  = 16'(FRAC_SHIFT - 150);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    function automatic logic [7:0] quantize(input logic [31:0] v);
        logic [7:0]         e;
        logic [23:0]        m;
        logic signed [15:0] s;
        logic [23:0]        sh;
        e = v[30:23];
        m = {1'b1, v[22:0]};
        s = $signed({8'd0, e}) + S_BIAS;
        sh = '0;
        if (e == 8'h00 || e == 8'hFF) sh = '0;
        else if (s >= 16'sd8)         sh = '0;
        else if (s >= 16'sd0)         sh = m << s[4:0];
        else if (s > -16'sd24)        sh = m >> 5'(-s);
        quantize = sh[7:0];
    endfunction

    state_t           state, state_next;
    logic             q_vld_p0;
    logic [7:0]       q_byte_p0;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count, count_next;
    logic             not_empty, full, push, pop, fire, can_emit;
    logic [7:0]       key, c_next;
    logic [CNT_W-1:0] cnt;

    // Stage p0: quantizer register ahead of the FIFO write
    always_ff @(posedge clk) begin
        if (reset) q_vld_p0 <= 1'b0;
        else       q_vld_p0 <= sawtooth_valid;
    end

    always_ff @(posedge clk) begin
        q_byte_p0 <= quantize(result[31:0]);
    end

    // Stage p1: key FIFO
    assign not_empty = (count != '0);
    assign full      = (count == FULL_CNT);
    assign key       = mem[rd_ptr];
    assign pop       = fire;
    // A full FIFO still accepts a write when the same cycle pops a key.
    assign push      = q_vld_p0 & (~full | pop);

    always_comb begin
        count_next = count;
        if (push && !pop)      count_next = count + (AW+1)'(1);
        else if (pop && !push) count_next = count - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= q_byte_p0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            key_afull    <= 1'b0;
            key_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count     <= count_next;
            key_afull <= (count_next >= AFULL_TH);
            if (q_vld_p0 && full && !pop) key_overflow <= 1'b1;
        end
    end

    // Stage p2: frame FSM and registered cipher output
    assign can_emit = ~cipher_tvalid | cipher_tready;

    always_comb begin
        state_next   = state;
        pixel_tready = 1'b0;
        fire         = 1'b0;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN: begin
                pixel_tready = not_empty & can_emit;
                fire         = pixel_tready & pixel_tvalid;
                if (fire && cnt == LAST_IDX) state_next = DRAIN;
            end
            DRAIN: if (cipher_tvalid && cipher_tready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef CIPHER_FEEDBACK_EN
    logic [7:0] chain;
    assign c_next = pixel_tdata ^ key ^ chain;

    always_ff @(posedge clk) begin
        if (reset)                      chain <= 8'h00;
        else if (state == IDLE && start) chain <= iv;
        else if (fire)                  chain <= c_next;
    end
`else
    logic unused_iv;
    assign unused_iv = ^iv;
    assign c_next    = pixel_tdata ^ key;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            cipher_tvalid <= 1'b0;
            cipher_tlast  <= 1'b0;
            cipher_tdata  <= 8'h00;
            frame_done    <= 1'b0;
            cnt           <= '0;
        end else begin
            state      <= state_next;
            frame_done <= 1'b0;
            if (state == IDLE && start) cnt <= '0;
            if (fire) begin
                cipher_tvalid <= 1'b1;
                cipher_tdata  <= c_next;
                cipher_tlast  <= (cnt == LAST_IDX);
                cnt           <= cnt + CNT_W'(1);
            end else if (cipher_tready) begin
                cipher_tvalid <= 1'b0;
                cipher_tlast  <= 1'b0;
            end
            if (state == DRAIN && cipher_tvalid && cipher_tready) frame_done <= 1'b1;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_chaos_keystream_xor.sv
// Scoreboard bench for chaos_keystream_xor with 8-pixel frames; follows CIPHER_FEEDBACK_EN if defined.
module tb_chaos_keystream_xor;
    logic        clk = 1'b0;
    logic        reset, sawtooth_valid, start, pixel_tvalid, cipher_tready;
    logic [31:0] result;
    logic [7:0]  iv, pixel_tdata;
    logic        key_afull, key_overflow, pixel_tready, cipher_tvalid, cipher_tlast, frame_done, busy;
    logic [7:0]  cipher_tdata;

    chaos_keystream_xor #(.FRAME_PIXELS(8)) dut (
        .clk(clk), .reset(reset), .sawtooth_valid(sawtooth_valid), .result(result),
        .key_afull(key_afull), .key_overflow(key_overflow), .start(start), .iv(iv),
        .pixel_tvalid(pixel_tvalid), .pixel_tready(pixel_tready), .pixel_tdata(pixel_tdata),
        .cipher_tvalid(cipher_tvalid), .cipher_tready(cipher_tready), .cipher_tdata(cipher_tdata),
        .cipher_tlast(cipher_tlast), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] keyq[$];
    logic [8:0] expq[$];
    logic [7:0] chain_m, last_c;
    int         pix_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [31:0] kf(input int i);
        return 32'h3F00_0000 | (32'(i) << 8);
    endfunction

    task automatic push_sample(input logic [31:0] r, input logic [7:0] k, input bit keep);
        sawtooth_valid = 1'b1;
        result = r;
        if (keep) keyq.push_back(k);
        step();
        sawtooth_valid = 1'b0;
    endtask

    task automatic load_keys(input int base);
        for (int i = 0; i < 8; i++) push_sample(kf(base + i), 8'(base + i), 1'b1);
        step();
        step();
    endtask

    task automatic start_frame(input logic [7:0] v);
        start = 1'b1;
        iv = v;
        step();
        start = 1'b0;
        chain_m = v;
        pix_m = 0;
    endtask

    task automatic model_push(input logic [7:0] p);
        logic [7:0] k, c;
        k = (keyq.size() != 0) ? keyq.pop_front() : 8'h00;
        c = p ^ k;
`ifdef CIPHER_FEEDBACK_EN
        c = c ^ chain_m;
`endif
        chain_m = c;
        last_c = c;
        expq.push_back({(pix_m == 7), c});
        pix_m++;
    endtask

    task automatic send_pixel(input logic [7:0] p);
        int n;
        n = 0;
        #1;
        pixel_tvalid = 1'b1;
        pixel_tdata = p;
        while (!pixel_tready && n < 50) begin
            step();
            n++;
        end
        if (!pixel_tready) check("pixel_tready_timeout", {31'd0, pixel_tready}, 32'd1);
        else model_push(p);
        step();
        pixel_tvalid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!frame_done && n < 30) begin
            step();
            n++;
        end
        check("frame_done", {31'd0, frame_done}, 32'd1);
        check("busy_after_done", {31'd0, busy}, 32'd0);
        step();
        check("frame_done_pulse", {31'd0, frame_done}, 32'd0);
    endtask

    // Monitor: every accepted cipher beat is compared against the scoreboard queue.
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (cipher_tvalid === 1'b1 && cipher_tready === 1'b1) begin
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL cipher_unexpected: got %0h, expected no beat", cipher_tdata);
                end else begin
                    e = expq.pop_front();
                    check("cipher_tdata", {24'd0, cipher_tdata}, {24'd0, e[7:0]});
                    check("cipher_tlast", {31'd0, cipher_tlast}, {31'd0, e[8]});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        reset = 1'b1; sawtooth_valid = 1'b0; result = '0; start = 1'b0; iv = '0;
        pixel_tvalid = 1'b0; pixel_tdata = '0; cipher_tready = 1'b1;
        repeat (3) step();
        check("rst_key_afull", {31'd0, key_afull}, 32'd0);
        check("rst_key_overflow", {31'd0, key_overflow}, 32'd0);
        check("rst_pixel_tready", {31'd0, pixel_tready}, 32'd0);
        check("rst_cipher_tvalid", {31'd0, cipher_tvalid}, 32'd0);
        check("rst_cipher_tdata", {24'd0, cipher_tdata}, 32'd0);
        check("rst_cipher_tlast", {31'd0, cipher_tlast}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        step();

        // Quantizer vectors feeding the first frame
        push_sample(32'h3F12_3456, 8'h34, 1'b1);
        push_sample(32'hBF12_3456, 8'h34, 1'b1);
        push_sample(32'h3B00_0000, 8'h80, 1'b1);
        push_sample(32'h3B80_0000, 8'h00, 1'b1);
        push_sample(32'h7FC0_0000, 8'h00, 1'b1);
        push_sample(32'h0000_0000, 8'h00, 1'b1);
        push_sample(32'h3F00_AB00, 8'hAB, 1'b1);
        push_sample(32'h3F00_CD00, 8'hCD, 1'b1);
        step();
        step();
        start_frame(8'h5A);
        check("busy_in_run", {31'd0, busy}, 32'd1);
        send_pixel(8'h11);
        send_pixel(8'h22);
        send_pixel(8'h33);
        send_pixel(8'h44);
        send_pixel(8'h55);
        send_pixel(8'h66);
        send_pixel(8'h77);
        send_pixel(8'h88);
        wait_done();

        // Backpressure
        load_keys(16);
        start_frame(8'h33);
        send_pixel(8'hA0);
        cipher_tready = 1'b0;
        pixel_tvalid = 1'b1;
        pixel_tdata = 8'hA1;
        repeat (5) begin
            step();
            check("bp_pixel_tready", {31'd0, pixel_tready}, 32'd0);
            check("bp_cipher_tvalid", {31'd0, cipher_tvalid}, 32'd1);
            check("bp_cipher_tdata", {24'd0, cipher_tdata}, {24'd0, last_c});
        end
        cipher_tready = 1'b1;
        for (int i = 1; i < 8; i++) send_pixel(8'hA0 + 8'(i));
        wait_done();

        // Key starvation
        start_frame(8'h01);
        pixel_tvalid = 1'b1;
        pixel_tdata = 8'h5C;
        repeat (3) begin
            step();
            check("starve_tready", {31'd0, pixel_tready}, 32'd0);
        end
        push_sample(kf(8'h77), 8'h77, 1'b1);
        check("starve_tready_q", {31'd0, pixel_tready}, 32'd0);
        step();
        check("starve_tready_key", {31'd0, pixel_tready}, 32'd1);
        if (pixel_tready) model_push(8'h5C);
        step();
        check("starve_one_only", {31'd0, pixel_tready}, 32'd0);
        pixel_tvalid = 1'b0;
        for (int i = 0; i < 7; i++) push_sample(kf(8'h60 + i), 8'(8'h60 + i), 1'b1);
        step();
        step();
        for (int i = 0; i < 7; i++) send_pixel(8'hC0 + 8'(i));
        wait_done();

        // Reset mid-frame
        load_keys(8'h40);
        start_frame(8'h44);
        send_pixel(8'h01);
        send_pixel(8'h02);
        send_pixel(8'h03);
        reset = 1'b1;
        seen = 1'b0;
        repeat (2) begin
            step();
            if (frame_done) seen = 1'b1;
        end
        reset = 1'b0;
        keyq.delete();
        repeat (4) begin
            step();
            if (frame_done) seen = 1'b1;
        end
        check("no_done_after_reset", {31'd0, seen}, 32'd0);
        check("idle_after_reset", {31'd0, busy}, 32'd0);
        load_keys(8'h50);
        start_frame(8'h00);
        for (int i = 0; i < 8; i++) send_pixel(8'hE0 + 8'(i));
        wait_done();

        // Overflow with no reads
        for (int i = 0; i < 66; i++) begin
            if (i == 8)  check("afull_below", {31'd0, key_afull}, 32'd0);
            if (i == 9)  check("afull_at_th", {31'd0, key_afull}, 32'd1);
            if (i == 65) check("ovf_not_yet", {31'd0, key_overflow}, 32'd0);
            push_sample(kf(i), 8'(i), (i < 64));
        end
        check("ovf_set", {31'd0, key_overflow}, 32'd1);
        check("afull_full", {31'd0, key_afull}, 32'd1);
        step();
        step();
        for (int f = 0; f < 8; f++) begin
            start_frame(8'(f));
            for (int j = 0; j < 8; j++) send_pixel(8'(j * 3 + f));
            wait_done();
        end
        check("ovf_sticky", {31'd0, key_overflow}, 32'd1);
        reset = 1'b1;
        step();
        step();
        check("rst2_key_afull", {31'd0, key_afull}, 32'd0);
        check("rst2_key_overflow", {31'd0, key_overflow}, 32'd0);
        check("rst2_busy", {31'd0, busy}, 32'd0);
        check("rst2_cipher_tvalid", {31'd0, cipher_tvalid}, 32'd0);
        reset = 1'b0;
        repeat (5) step();
        check("scoreboard_drained", expq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
